// File: rtl/wb_regfile_pkg.sv
// Shared pipeline header for the writeback register file: FSM encodings,
// default sizes and the logic-level helpers used across the block.
package wb_regfile_pkg;

  localparam int DEF_BUS_SIZE      = 32;
  localparam int DEF_REG_ADDR_SIZE = 5;
  localparam int DEF_REGISTERS     = 32;

  localparam logic LOW   = 1'b0;
  localparam logic HIGH  = 1'b1;
  // Level at which the active-low reset is asserted.
  localparam logic CLEAR = LOW;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    DUMP   = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/wb_regfile_if.sv
// Register-dump stream: start request, valid/ready beat handshake and completion flag.
interface wb_regfile_if #(
  parameter int BUS_SIZE      = 32,
  parameter int REG_ADDR_SIZE = 5
) ();

  logic                     i_dump_start;
  logic                     o_dump_valid;
  logic                     i_dump_ready;
  logic [REG_ADDR_SIZE-1:0] o_dump_addr;
  logic [BUS_SIZE-1:0]      o_dump_data;
  logic                     o_dump_done;

  modport slave (
    input  i_dump_start,
    output o_dump_valid,
    input  i_dump_ready,
    output o_dump_addr,
    output o_dump_data,
    output o_dump_done
  );

  modport master (
    output i_dump_start,
    input  o_dump_valid,
    output i_dump_ready,
    input  o_dump_addr,
    input  o_dump_data,
    input  o_dump_done
  );

endinterface

// File: rtl/regfile_core.sv
// Register storage with two bypassed decode read ports and one plain dump read port.
// Register 0 has no storage and always reads as zero.
module regfile_core
  import wb_regfile_pkg::*;
#(
  parameter int BUS_SIZE      = DEF_BUS_SIZE,
  parameter int REG_ADDR_SIZE = DEF_REG_ADDR_SIZE,
  parameter int REGISTERS     = DEF_REGISTERS
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_we,
  input  logic [REG_ADDR_SIZE-1:0] i_wa,
  input  logic [BUS_SIZE-1:0]      i_wd,
  input  logic [REG_ADDR_SIZE-1:0] i_ra_a,
  output logic [BUS_SIZE-1:0]      o_rd_a,
  input  logic [REG_ADDR_SIZE-1:0] i_ra_b,
  output logic [BUS_SIZE-1:0]      o_rd_b,
  input  logic [REG_ADDR_SIZE-1:0] i_ra_d,
  output logic [BUS_SIZE-1:0]      o_rd_d
);

  logic [BUS_SIZE-1:0] r_regs [1:REGISTERS-1];
  logic [REGISTERS-1:1] w_sel;
  logic                 w_we;

  assign w_we = i_we && (i_wa != '0);

  genvar gi;
  generate
    for (gi = 1; gi < REGISTERS; gi++) begin : g_sel
      assign w_sel[gi] = w_we && (i_wa == REG_ADDR_SIZE'(gi));
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (i_reset == CLEAR) begin
      for (int i = 1; i < REGISTERS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 1; i < REGISTERS; i++) begin
        if (w_sel[i]) r_regs[i] <= i_wd;
      end
    end
  end

  // The beat being written is visible to decode in the same cycle.
  always_comb begin
    o_rd_a = '0;
    o_rd_b = '0;
    o_rd_d = '0;
    for (int i = 1; i < REGISTERS; i++) begin
      if (i_ra_a == REG_ADDR_SIZE'(i)) o_rd_a = r_regs[i];
      if (i_ra_b == REG_ADDR_SIZE'(i)) o_rd_b = r_regs[i];
      if (i_ra_d == REG_ADDR_SIZE'(i)) o_rd_d = r_regs[i];
    end
    if (w_we && (i_ra_a == i_wa)) o_rd_a = i_wd;
    if (w_we && (i_ra_b == i_wa)) o_rd_b = i_wd;
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage register file: result mux, halt/dump FSM and the register dump
// sequencer that streams every register out once the processor has halted.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int BUS_SIZE      = DEF_BUS_SIZE,
  parameter int REG_ADDR_SIZE = DEF_REG_ADDR_SIZE,
  parameter int REGISTERS     = DEF_REGISTERS
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_wb,
  input  logic                     i_mem_to_reg,
  input  logic                     i_halt,
  input  logic [BUS_SIZE-1:0]      i_mem_result,
  input  logic [BUS_SIZE-1:0]      i_alu_result,
  input  logic [REG_ADDR_SIZE-1:0] i_addr_wr,
  input  logic [REG_ADDR_SIZE-1:0] i_rs_addr,
  input  logic [REG_ADDR_SIZE-1:0] i_rt_addr,
  output logic [BUS_SIZE-1:0]      o_rs_data,
  output logic [BUS_SIZE-1:0]      o_rt_data,
  output logic                     o_wb_en,
  output logic [REG_ADDR_SIZE-1:0] o_wb_addr,
  output logic [BUS_SIZE-1:0]      o_wb_data,
  output logic                     o_halted,
  wb_regfile_if.slave              io_dump
);

  localparam logic [REG_ADDR_SIZE-1:0] LAST_IDX = REG_ADDR_SIZE'(REGISTERS - 1);

  state_t                   r_state;
  state_t                   w_state_next;
  logic [REG_ADDR_SIZE-1:0] r_idx;
  logic [REG_ADDR_SIZE-1:0] w_idx_next;
  logic [BUS_SIZE-1:0]      w_wb_data;
  logic                     w_wb_en;
  logic [BUS_SIZE-1:0]      w_dump_data;

  assign w_wb_data = i_mem_to_reg ? i_mem_result : i_alu_result;
  assign w_wb_en   = i_enable && i_wb && (i_addr_wr != '0) && (r_state == RUN);

  assign o_wb_en   = w_wb_en;
  assign o_wb_addr = i_addr_wr;
  assign o_wb_data = w_wb_data;

  regfile_core #(
    .BUS_SIZE     (BUS_SIZE),
    .REG_ADDR_SIZE(REG_ADDR_SIZE),
    .REGISTERS    (REGISTERS)
  ) u_core (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_we   (w_wb_en),
    .i_wa   (i_addr_wr),
    .i_wd   (w_wb_data),
    .i_ra_a (i_rs_addr),
    .o_rd_a (o_rs_data),
    .i_ra_b (i_rt_addr),
    .o_rd_b (o_rt_data),
    .i_ra_d (r_idx),
    .o_rd_d (w_dump_data)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (i_reset == CLEAR) begin
      r_state <= RUN;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      RUN: begin
        if (i_enable && i_halt) w_state_next = HALTED;
      end
      HALTED, DONE: begin
        if (io_dump.i_dump_start) begin
          w_state_next = DUMP;
          w_idx_next   = '0;
        end
      end
      DUMP: begin
        // The last index is kept rather than wrapped so DONE still points at it.
        if (io_dump.i_dump_ready) begin
          if (r_idx == LAST_IDX) w_state_next = DONE;
          else                   w_idx_next   = r_idx + REG_ADDR_SIZE'(1);
        end
      end
      default: w_state_next = RUN;
    endcase
  end

  assign o_halted             = (r_state != RUN) ? HIGH : LOW;
  assign io_dump.o_dump_valid = (r_state == DUMP) ? HIGH : LOW;
  assign io_dump.o_dump_done  = (r_state == DONE) ? HIGH : LOW;
  assign io_dump.o_dump_addr  = r_idx;
  assign io_dump.o_dump_data  = w_dump_data;

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameters: BUS_SIZE, default 32, data width; REG_ADDR_SIZE, default 5, register index width; REGISTERS, default 32, register count.
REQ-002 SHALL have port i_clk, input, 1, single clock, all state on rising edge.
REQ-003 SHALL have port i_reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port i_enable, input, 1, pipeline advance qualifier for the writeback beat.
REQ-005 SHALL have ports i_wb, i_mem_to_reg, i_halt, input, 1 each: writeback-stage control bits.
REQ-006 SHALL have ports i_mem_result and i_alu_result, input, BUS_SIZE each: writeback-stage data.
REQ-007 SHALL have port i_addr_wr, input, REG_ADDR_SIZE, destination register.
REQ-008 SHALL have ports i_rs_addr and i_rt_addr, input, REG_ADDR_SIZE each; o_rs_data and o_rt_data, output, BUS_SIZE each: decode read ports.
REQ-009 SHALL have ports o_wb_en, output, 1; o_wb_addr, output, REG_ADDR_SIZE; o_wb_data, output, BUS_SIZE: the effective write, exported for forwarding.
REQ-010 SHALL have port o_halted, output, 1, processor halted.
REQ-011 SHALL have port i_dump_start, input, 1, one-cycle request to stream all registers.
REQ-012 SHALL have dump stream ports o_dump_valid, output, 1; i_dump_ready, input, 1; o_dump_addr, output, REG_ADDR_SIZE; o_dump_data, output, BUS_SIZE.
REQ-013 SHALL have port o_dump_done, output, 1, full register set transferred.

Function
REQ-014 SHALL compute o_wb_data = i_mem_to_reg ? i_mem_result : i_alu_result, combinationally.
REQ-015 SHALL drive o_wb_en = i_enable && i_wb && (i_addr_wr != 0) && state==RUN.
REQ-016 SHALL drive o_wb_addr = i_addr_wr.
REQ-017 SHALL write o_wb_data into register i_addr_wr on the rising edge when o_wb_en=1.
REQ-018 SHALL hardwire register 0 to zero, so a read of index 0 returns 0 regardless of writes.
REQ-019 SHALL make both read ports combinational, with write-through bypass: if o_wb_en and read addr == i_addr_wr, return o_wb_data in the same cycle.
REQ-020 SHALL implement FSM states RUN, HALTED, DUMP and DONE.
REQ-021 SHALL transition RUN->HALTED on the edge where i_enable && i_halt; a write in that same beat SHALL still be performed.
REQ-022 SHALL ignore all writeback inputs in HALTED, DUMP and DONE (o_wb_en=0).
REQ-023 SHALL drive o_halted=1 in every state except RUN.
REQ-024 SHALL transition HALTED->DUMP, or DONE->DUMP, on i_dump_start=1, loading the dump index with 0.
REQ-025 SHALL ignore i_dump_start in RUN and DUMP.
REQ-026 SHALL drive o_dump_valid=1 only in DUMP, with o_dump_addr=index and o_dump_data=register[index].
REQ-027 SHALL hold o_dump_addr and o_dump_data stable while o_dump_valid=1 and i_dump_ready=0.
REQ-028 SHALL increment the index by 1 on a transfer (o_dump_valid && i_dump_ready).
REQ-029 SHALL go DUMP->DONE on the transfer of index REGISTERS-1, without wrapping the index.
REQ-030 SHALL assert o_dump_done=1 in DONE only, and deassert it on re-entry to DUMP.
REQ-031 SHALL allow a transfer on the first DUMP cycle, so REGISTERS transfers take REGISTERS cycles with i_dump_ready held at 1.

Reset
REQ-032 SHALL, on i_reset=0 asynchronously: clear all registers to 0, set state=RUN, index=0, and drive o_halted, o_dump_valid and o_dump_done to 0.
REQ-033 SHALL abort, on reset asserted mid-DUMP, the transfer with no further valid beat; operation SHALL resume in RUN after reset release.

Structure
REQ-034 SHALL place the FSM state encodings, the BUS_SIZE/REG_ADDR_SIZE/REGISTERS defaults, and the LOW/HIGH/CLEAR helpers in the shared pipeline header.
REQ-035 SHALL implement the storage array with read bypass as one sub-module, regfile_core; the FSM, dump sequencer and writeback mux stay in wb_regfile.

Verification
REQ-036 SHALL cover: write alu 0xDEADBEEF to r5 (mem_to_reg=0) -> next cycle o_rs_data=0xDEADBEEF with rs=5; same cycle rt=5 bypass -> 0xDEADBEEF.
REQ-037 SHALL cover: mem_to_reg=1, mem_result=0x12345678, alu=0xFFFFFFFF, addr=0 -> no write, read r0=0, o_wb_en=0.
REQ-038 SHALL cover: i_halt with write r7=0x7 in the same beat -> o_halted=1 next cycle, r7=0x7; subsequent write r8=0x8 is ignored and r8 stays 0.
REQ-039 SHALL cover: after halt, i_dump_start with ready=1 -> 32 beats, addr 0..31, data matches the model, o_dump_done=1 after the 32nd beat.
REQ-040 SHALL cover: ready toggled 1-0-0-1 during the dump -> addr/data held during stall, no skipped or duplicated index.
REQ-041 SHALL cover: i_reset=0 at index 10 mid-dump -> valid drops immediately, all registers read 0, state RUN.
